// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch/lap core.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] MS10_MAX = 8'd99;
    localparam logic [7:0] SEC_MAX  = 8'd59;
    localparam int unsigned LAP_W = 24;

    typedef logic [LAP_W-1:0] lap_t;

    function automatic logic [7:0] sat8(input logic [7:0] v, input logic [7:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/stopwatch_lap_core_if.sv
// Control/status bundle between the button front end, the core and the display formatter.
interface stopwatch_lap_core_if #(
    parameter int unsigned LAP_DEPTH = 4
);
    import stopwatch_pkg::*;

    logic                       run;
    logic                       mode_down;
    logic                       clear_btn;
    logic                       lap_btn;
    logic                       load;
    logic [7:0]                 preset_min;
    logic [7:0]                 preset_sec;
    logic [7:0]                 preset_ms10;
    logic                       lap_rd;
    logic [7:0]                 minute;
    logic [7:0]                 second;
    logic [7:0]                 ms10;
    logic                       running;
    logic                       done;
    logic                       ovf;
    logic                       lap_valid;
    lap_t                       lap_data;
    logic [$clog2(LAP_DEPTH):0] lap_cnt;
    logic                       lap_lost;

    modport master (
        output run, mode_down, clear_btn, lap_btn, load,
        output preset_min, preset_sec, preset_ms10, lap_rd,
        input  minute, second, ms10, running, done, ovf,
        input  lap_valid, lap_data, lap_cnt, lap_lost
    );

    modport slave (
        input  run, mode_down, clear_btn, lap_btn, load,
        input  preset_min, preset_sec, preset_ms10, lap_rd,
        output minute, second, ms10, running, done, ovf,
        output lap_valid, lap_data, lap_cnt, lap_lost
    );

endinterface

// File: rtl/stopwatch_lap_core_lap_fifo.sv
// Lap capture FIFO: circular buffer whose push overwrites the oldest entry when full.
module lap_fifo
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  lap_t                   din,
    output lap_t                   data,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] cnt,
    output logic                   lost
);
    localparam int unsigned AW = $clog2(DEPTH);

    lap_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          pop_ok;

    assign full   = (count == (AW+1)'(DEPTH));
    assign pop_ok = pop && (count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            lost   <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            lost   <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            // A push into a full buffer drops the head unless a pop already freed it.
            if (pop_ok || (push && full))
                rd_ptr <= rd_ptr + 1'b1;
            if (push && full && !pop_ok)
                lost <= 1'b1;
            if (push && !pop_ok && !full)
                count <= count + 1'b1;
            else if (pop_ok && !push)
                count <= count - 1'b1;
        end
    end

    assign valid = (count != '0);
    assign data  = valid ? mem[rd_ptr] : '0;
    assign cnt   = count;

endmodule

// File: rtl/stopwatch_lap_core.sv
// Stopwatch/countdown core: prescaled time base, min/sec/10ms counters, lap capture FIFO.
module stopwatch_lap_core
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 1_000_000,
    parameter int unsigned TICK_HZ   = 100,
    parameter int unsigned MIN_MAX   = 99,
    parameter int unsigned LAP_DEPTH = 4
) (
    input logic                 mclk,
    input logic                 reset,
    stopwatch_lap_core_if.slave bus
);
    localparam int unsigned     DIV     = CLK_HZ / TICK_HZ;
    localparam int unsigned     PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   PRE_TOP = PW'(DIV - 1);
    localparam logic [7:0]      MIN_TOP = 8'(MIN_MAX);

    state_t        state;
    state_t        state_nx;
    logic          mode_dn;
    logic [1:0]    clr_sync;
    logic [1:0]    lap_sync;
    logic          clr_dly;
    logic          lap_dly;
    logic          clr_edge;
    logic          lap_edge;
    logic          clr_do;
    logic          load_do;
    logic          lap_push;
    logic          tick;
    logic          at_zero;
    logic          at_one;
    logic [PW-1:0] presc;
    logic [7:0]    min_q;
    logic [7:0]    sec_q;
    logic [7:0]    ms_q;
    logic          ovf_q;

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            clr_sync <= '0;
            lap_sync <= '0;
            clr_dly  <= 1'b0;
            lap_dly  <= 1'b0;
        end else begin
            clr_sync <= {clr_sync[0], bus.clear_btn};
            lap_sync <= {lap_sync[0], bus.lap_btn};
            clr_dly  <= clr_sync[1];
            lap_dly  <= lap_sync[1];
        end
    end

    assign clr_edge = clr_sync[1] & ~clr_dly;
    assign lap_edge = lap_sync[1] & ~lap_dly;
    assign clr_do   = clr_edge && (state != ST_RUN);
    assign load_do  = bus.load && (state != ST_RUN);
    assign lap_push = lap_edge && (state == ST_RUN);
    assign tick     = (state == ST_RUN) && (presc == PRE_TOP);
    assign at_zero  = (min_q == '0) && (sec_q == '0) && (ms_q == '0);
    assign at_one   = (min_q == '0) && (sec_q == '0) && (ms_q == 8'd1);

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) state <= ST_STOP;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_STOP: if (!clr_do && !bus.load && bus.run && !(bus.mode_down && at_zero))
                         state_nx = ST_RUN;
            ST_RUN:  if (tick && mode_dn && at_one) state_nx = ST_DONE;
                     else if (!bus.run)             state_nx = ST_STOP;
            ST_DONE: if (clr_do || bus.load) state_nx = ST_STOP;
            default: state_nx = ST_STOP;
        endcase
    end

    always_comb begin
        bus.running = (state == ST_RUN);
        bus.done    = (state == ST_DONE);
    end

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset)                 mode_dn <= 1'b0;
        else if (state == ST_STOP)  mode_dn <= bus.mode_down;
    end

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            presc <= '0;
            min_q <= '0;
            sec_q <= '0;
            ms_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= 1'b0;
            if (clr_do) begin
                presc <= '0;
                min_q <= '0;
                sec_q <= '0;
                ms_q  <= '0;
            end else if (load_do) begin
                presc <= '0;
                min_q <= sat8(bus.preset_min, MIN_TOP);
                sec_q <= sat8(bus.preset_sec, SEC_MAX);
                ms_q  <= sat8(bus.preset_ms10, MS10_MAX);
            end else if (state == ST_RUN) begin
                presc <= tick ? '0 : presc + 1'b1;
                if (tick && !mode_dn) begin
                    if (ms_q != MS10_MAX) ms_q <= ms_q + 8'd1;
                    else begin
                        ms_q <= '0;
                        if (sec_q != SEC_MAX) sec_q <= sec_q + 8'd1;
                        else begin
                            sec_q <= '0;
                            if (min_q != MIN_TOP) min_q <= min_q + 8'd1;
                            else begin
                                min_q <= '0;
                                ovf_q <= 1'b1;
                            end
                        end
                    end
                end else if (tick) begin
                    // Down count never starts from zero, so the minute borrow cannot underflow.
                    if (ms_q != '0) ms_q <= ms_q - 8'd1;
                    else begin
                        ms_q <= MS10_MAX;
                        if (sec_q != '0) sec_q <= sec_q - 8'd1;
                        else begin
                            sec_q <= SEC_MAX;
                            min_q <= min_q - 8'd1;
                        end
                    end
                end
            end
        end
    end

    assign bus.minute = min_q;
    assign bus.second = sec_q;
    assign bus.ms10   = ms_q;
    assign bus.ovf    = ovf_q;

    lap_fifo #(.DEPTH(LAP_DEPTH)) u_lap_fifo (
        .clk   (mclk),
        .rst_n (reset),
        .push  (lap_push),
        .pop   (bus.lap_rd),
        .flush (clr_do),
        .din   ({min_q, sec_q, ms_q}),
        .data  (bus.lap_data),
        .valid (bus.lap_valid),
        .cnt   (bus.lap_cnt),
        .lost  (bus.lap_lost)
    );

endmodule

// File: tb/tb_stopwatch_lap_core.sv
// Directed bench for stopwatch_lap_core at DIV=10, MIN_MAX=2, LAP_DEPTH=4.
module tb_stopwatch_lap_core;
    import stopwatch_pkg::*;

    logic mclk;
    logic reset;
    int   vectors;
    int   errors;
    logic [23:0] tnow;

    stopwatch_lap_core_if #(.LAP_DEPTH(4)) bus ();

    stopwatch_lap_core #(
        .CLK_HZ    (1000),
        .TICK_HZ   (100),
        .MIN_MAX   (2),
        .LAP_DEPTH (4)
    ) dut (
        .mclk  (mclk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    assign tnow = {bus.minute, bus.second, bus.ms10};

    function automatic logic [23:0] tv(input int m, input int s, input int c);
        return {m[7:0], s[7:0], c[7:0]};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    task automatic do_clear();
        bus.clear_btn = 1'b1;
        step(3);
        bus.clear_btn = 1'b0;
        step(3);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(2);
        vectors++; if (tnow !== 24'h0) begin errors++; $display("FAIL reset_time got %h want %h", tnow, 24'h0); end
        vectors++; if (bus.running !== 1'b0 || bus.done !== 1'b0 || bus.ovf !== 1'b0) begin
            errors++; $display("FAIL reset_flags got run=%b done=%b ovf=%b want 0 0 0", bus.running, bus.done, bus.ovf); end
        vectors++; if (bus.lap_valid !== 1'b0 || bus.lap_cnt !== 3'd0 || bus.lap_lost !== 1'b0 || bus.lap_data !== 24'h0) begin
            errors++; $display("FAIL reset_fifo got v=%b c=%0d l=%b d=%h want 0 0 0 0", bus.lap_valid, bus.lap_cnt, bus.lap_lost, bus.lap_data); end
        reset = 1'b1;
        step(1);
    endtask

    task automatic test_up_count();
        bus.run = 1'b1;
        step(1);
        vectors++; if (bus.running !== 1'b1) begin errors++; $display("FAIL up_enter running got %b want 1", bus.running); end
        for (int n = 1; n <= 1000; n++) begin
            step(1);
            if (n == 9) begin
                vectors++; if (tnow !== tv(0,0,0)) begin errors++; $display("FAIL up_n9 got %h want %h", tnow, tv(0,0,0)); end
            end
            if (n == 10) begin
                vectors++; if (tnow !== tv(0,0,1)) begin errors++; $display("FAIL up_n10 got %h want %h", tnow, tv(0,0,1)); end
            end
            if (n == 19) begin
                vectors++; if (tnow !== tv(0,0,1)) begin errors++; $display("FAIL up_n19 got %h want %h", tnow, tv(0,0,1)); end
            end
            if (n == 20) begin
                vectors++; if (tnow !== tv(0,0,2)) begin errors++; $display("FAIL up_n20 got %h want %h", tnow, tv(0,0,2)); end
            end
            if (n == 1000) begin
                vectors++; if (tnow !== tv(0,1,0)) begin errors++; $display("FAIL up_1000 got %h want %h", tnow, tv(0,1,0)); end
            end
        end
        bus.run = 1'b0;
        step(6);
        vectors++; if (bus.running !== 1'b0 || tnow !== tv(0,1,0)) begin
            errors++; $display("FAIL up_hold got run=%b t=%h want 0 %h", bus.running, tnow, tv(0,1,0)); end
    endtask

    task automatic test_overflow();
        bus.preset_min = 8'd9; bus.preset_sec = 8'd70; bus.preset_ms10 = 8'd120;
        bus.load = 1'b1;
        step(1);
        bus.load = 1'b0;
        vectors++; if (tnow !== tv(2,59,99)) begin errors++; $display("FAIL load_sat got %h want %h", tnow, tv(2,59,99)); end
        bus.run = 1'b1;
        step(10);
        vectors++; if (tnow !== tv(2,59,99) || bus.ovf !== 1'b0) begin
            errors++; $display("FAIL ovf_pre got t=%h ovf=%b want %h 0", tnow, bus.ovf, tv(2,59,99)); end
        step(1);
        vectors++; if (tnow !== tv(0,0,0) || bus.ovf !== 1'b1 || bus.running !== 1'b1) begin
            errors++; $display("FAIL ovf_wrap got t=%h ovf=%b run=%b want 0 1 1", tnow, bus.ovf, bus.running); end
        step(1);
        vectors++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL ovf_pulse got %b want 0", bus.ovf); end
        bus.run = 1'b0;
        step(1);
    endtask

    task automatic test_down();
        bus.mode_down = 1'b1;
        bus.preset_min = 8'd0; bus.preset_sec = 8'd1; bus.preset_ms10 = 8'd0;
        bus.load = 1'b1;
        step(1);
        bus.load = 1'b0;
        bus.run = 1'b1;
        step(11);
        vectors++; if (tnow !== tv(0,0,99)) begin errors++; $display("FAIL down_first got %h want %h", tnow, tv(0,0,99)); end
        step(989);
        vectors++; if (tnow !== tv(0,0,1) || bus.done !== 1'b0) begin
            errors++; $display("FAIL down_99 got t=%h done=%b want %h 0", tnow, bus.done, tv(0,0,1)); end
        step(1);
        vectors++; if (tnow !== tv(0,0,0) || bus.done !== 1'b1 || bus.running !== 1'b0) begin
            errors++; $display("FAIL down_done got t=%h done=%b run=%b want 0 1 0", tnow, bus.done, bus.running); end
        step(20);
        vectors++; if (tnow !== tv(0,0,0) || bus.done !== 1'b1) begin
            errors++; $display("FAIL down_hold got t=%h done=%b want 0 1", tnow, bus.done); end
        bus.preset_sec = 8'd0;
        bus.load = 1'b1;
        step(1);
        bus.load = 1'b0;
        step(5);
        vectors++; if (bus.done !== 1'b0 || bus.running !== 1'b0) begin
            errors++; $display("FAIL down_zero_start got done=%b run=%b want 0 0", bus.done, bus.running); end
        bus.run = 1'b0;
        bus.mode_down = 1'b0;
        step(1);
    endtask

    task automatic test_pause();
        do_clear();
        bus.run = 1'b1;
        step(25);
        bus.run = 1'b0;
        step(1);
        step(49);
        vectors++; if (tnow !== tv(0,0,2) || bus.running !== 1'b0) begin
            errors++; $display("FAIL pause_hold got t=%h run=%b want %h 0", tnow, bus.running, tv(0,0,2)); end
        bus.run = 1'b1;
        step(5);
        vectors++; if (tnow !== tv(0,0,2)) begin errors++; $display("FAIL resume_4 got %h want %h", tnow, tv(0,0,2)); end
        step(1);
        vectors++; if (tnow !== tv(0,0,3)) begin errors++; $display("FAIL resume_5 got %h want %h", tnow, tv(0,0,3)); end
        bus.run = 1'b0;
        step(1);
    endtask

    task automatic test_laps();
        logic [23:0] exp_q [4];
        exp_q[0] = tv(0,0,2); exp_q[1] = tv(0,0,4); exp_q[2] = tv(0,0,6); exp_q[3] = tv(0,0,8);
        do_clear();
        bus.lap_btn = 1'b1;
        step(3);
        bus.lap_btn = 1'b0;
        step(3);
        vectors++; if (bus.lap_cnt !== 3'd0) begin errors++; $display("FAIL lap_stop got %0d want 0", bus.lap_cnt); end
        bus.run = 1'b1;
        step(8);
        for (int k = 0; k < 5; k++) begin
            bus.lap_btn = 1'b1;
            step(3);
            bus.lap_btn = 1'b0;
            if (k == 0) begin
                vectors++; if (bus.lap_data !== tv(0,0,0)) begin
                    errors++; $display("FAIL lap_pretick got %h want %h", bus.lap_data, tv(0,0,0)); end
            end
            if (k == 3) begin
                vectors++; if (bus.lap_cnt !== 3'd4 || bus.lap_lost !== 1'b0) begin
                    errors++; $display("FAIL lap_full got c=%0d l=%b want 4 0", bus.lap_cnt, bus.lap_lost); end
            end
            step(17);
        end
        vectors++; if (bus.lap_cnt !== 3'd4 || bus.lap_lost !== 1'b1 || bus.lap_valid !== 1'b1) begin
            errors++; $display("FAIL lap_over got c=%0d l=%b v=%b want 4 1 1", bus.lap_cnt, bus.lap_lost, bus.lap_valid); end
        bus.run = 1'b0;
        step(1);
        for (int i = 0; i < 4; i++) begin
            vectors++; if (bus.lap_data !== exp_q[i]) begin
                errors++; $display("FAIL lap_pop%0d got %h want %h", i, bus.lap_data, exp_q[i]); end
            bus.lap_rd = 1'b1;
            step(1);
            bus.lap_rd = 1'b0;
            vectors++; if (bus.lap_cnt !== 3'(3 - i)) begin
                errors++; $display("FAIL lap_cnt%0d got %0d want %0d", i, bus.lap_cnt, 3 - i); end
        end
        bus.lap_rd = 1'b1;
        step(1);
        bus.lap_rd = 1'b0;
        vectors++; if (bus.lap_cnt !== 3'd0 || bus.lap_valid !== 1'b0) begin
            errors++; $display("FAIL lap_empty_rd got c=%0d v=%b want 0 0", bus.lap_cnt, bus.lap_valid); end
    endtask

    task automatic test_back_to_back();
        bus.preset_min = 8'd0; bus.preset_sec = 8'd0; bus.preset_ms10 = 8'd0;
        bus.load = 1'b1;
        step(1);
        bus.load = 1'b0;
        bus.run = 1'b1;
        step(1);
        bus.lap_btn = 1'b1;
        step(3);
        bus.lap_btn = 1'b0;
        vectors++; if (bus.lap_cnt !== 3'd1 || bus.lap_data !== tv(0,0,0)) begin
            errors++; $display("FAIL b2b_first got c=%0d d=%h want 1 %h", bus.lap_cnt, bus.lap_data, tv(0,0,0)); end
        step(17);
        bus.lap_btn = 1'b1;
        step(2);
        bus.lap_rd = 1'b1;
        step(1);
        bus.lap_rd = 1'b0;
        bus.lap_btn = 1'b0;
        vectors++; if (bus.lap_cnt !== 3'd1 || bus.lap_data !== tv(0,0,2) || bus.lap_lost !== 1'b1) begin
            errors++; $display("FAIL b2b_pushpop got c=%0d d=%h l=%b want 1 %h 1", bus.lap_cnt, bus.lap_data, bus.lap_lost, tv(0,0,2)); end
    endtask

    task automatic test_clear();
        bus.clear_btn = 1'b1;
        step(3);
        vectors++; if (bus.running !== 1'b1 || bus.lap_cnt !== 3'd1 || bus.lap_lost !== 1'b1 || tnow === 24'h0) begin
            errors++; $display("FAIL clear_in_run got run=%b c=%0d l=%b t=%h want 1 1 1 nonzero", bus.running, bus.lap_cnt, bus.lap_lost, tnow); end
        bus.clear_btn = 1'b0;
        step(3);
        bus.run = 1'b0;
        step(1);
        bus.clear_btn = 1'b1;
        step(2);
        vectors++; if (bus.lap_cnt !== 3'd1) begin errors++; $display("FAIL clear_early got c=%0d want 1", bus.lap_cnt); end
        step(1);
        vectors++; if (tnow !== 24'h0 || bus.lap_cnt !== 3'd0 || bus.lap_valid !== 1'b0 || bus.lap_lost !== 1'b0) begin
            errors++; $display("FAIL clear_stop got t=%h c=%0d v=%b l=%b want 0 0 0 0", tnow, bus.lap_cnt, bus.lap_valid, bus.lap_lost); end
        bus.clear_btn = 1'b0;
        step(3);
        bus.preset_min = 8'd1; bus.preset_sec = 8'd2; bus.preset_ms10 = 8'd3;
        bus.load = 1'b1;
        step(1);
        bus.load = 1'b0;
        vectors++; if (tnow !== tv(1,2,3)) begin errors++; $display("FAIL load_plain got %h want %h", tnow, tv(1,2,3)); end
        bus.clear_btn = 1'b1;
        step(2);
        bus.preset_sec = 8'd30; bus.preset_ms10 = 8'd40;
        bus.load = 1'b1;
        step(1);
        bus.load = 1'b0;
        vectors++; if (tnow !== 24'h0) begin errors++; $display("FAIL clear_vs_load got %h want %h", tnow, 24'h0); end
        bus.clear_btn = 1'b0;
        step(3);
    endtask

    task automatic test_reset_midrun();
        bus.run = 1'b1;
        step(15);
        vectors++; if (tnow !== tv(0,0,1)) begin errors++; $display("FAIL midrun_pre got %h want %h", tnow, tv(0,0,1)); end
        reset = 1'b0;
        #1;
        vectors++; if (tnow !== 24'h0 || bus.running !== 1'b0) begin
            errors++; $display("FAIL midrun_async got t=%h run=%b want 0 0", tnow, bus.running); end
        step(2);
        reset = 1'b1;
        step(11);
        vectors++; if (tnow !== tv(0,0,1)) begin errors++; $display("FAIL midrun_resume got %h want %h", tnow, tv(0,0,1)); end
        bus.run = 1'b0;
        step(1);
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        reset   = 1'b0;
        bus.run = 1'b0; bus.mode_down = 1'b0; bus.clear_btn = 1'b0; bus.lap_btn = 1'b0;
        bus.load = 1'b0; bus.lap_rd = 1'b0;
        bus.preset_min = 8'd0; bus.preset_sec = 8'd0; bus.preset_ms10 = 8'd0;
        test_reset();
        test_up_count();
        test_overflow();
        test_down();
        test_pause();
        test_laps();
        test_back_to_back();
        test_clear();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_lap_core.md
# stopwatch_lap_core

Parametrised stopwatch/countdown core: a prescaled time base drives minute/second/10 ms counters in count-up or count-down mode, with a lap-capture FIFO. It sits between the button debouncers and the seven-segment/display formatter, in the same position as the current single-mode timer. It is generalised in tick rate, minute range and lap depth. It fixes second/minute roll-over at 59/MIN_MAX.

## Interface
- CLK_HZ, 1_000_000: mclk frequency.
- TICK_HZ, 100: count rate; DIV = CLK_HZ/TICK_HZ, which must be ≥ 2.
- MIN_MAX, 99: largest minute value, ≤ 255.
- LAP_DEPTH, 4: lap FIFO entries, a power of two, ≥ 2.
- mclk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- run  in  1  level; 1 = count, 0 = hold.
- mode_down  in  1  level; sampled only while stopped. 1 = countdown.
- clear_btn  in  1  debounced level; its rising edge clears the core.
- lap_btn  in  1  debounced level; its rising edge captures a lap.
- load  in  1  single-cycle pulse; loads preset while stopped.
- preset_min, preset_sec, preset_ms10  in  8 each  load values, binary.
- lap_rd  in  1  single-cycle pulse; pops the FIFO head.
- minute, second, ms10  out  8 each  current time, binary.
- running  out  1  core is in RUN.
- done  out  1  countdown reached 0:00:00.
- ovf  out  1  one-cycle pulse on count-up wrap.
- lap_valid  out  1  FIFO not empty.
- lap_data  out  24  FIFO head {minute, second, ms10}.
- lap_cnt  out  $clog2(LAP_DEPTH)+1  FIFO occupancy.
- lap_lost  out  1  sticky; set when a lap overwrote the oldest entry.

## Operation
- States: STOP, RUN, DONE.
  - STOP→RUN when run=1 and the time is not 0:00:00 in down mode.
  - RUN→STOP when run=0.
  - RUN→DONE when a down-count reaches 0:00:00.
  - DONE→STOP on a clear edge or load.
- mode register: latched from mode_down while in STOP; held constant in RUN and DONE.
- Edge detection: clear_btn and lap_btn each pass through a 2-flop synchroniser plus a delay flop. An edge is a 0→1 of the synchronised signal.
- Prescaler: counts 0..DIV-1 only in RUN. tick fires when it equals DIV-1, then the prescaler returns to 0. It holds its value in STOP, so a pause/resume loses no partial tick.
- Up count:
  - ms10 0..99, carrying into second.
  - second 0..59, carrying into minute.
  - minute 0..MIN_MAX.
  - A tick at MIN_MAX:59:99 gives 0:00:00, pulses ovf, and the core stays in RUN.
- Down count: borrows in reverse order. 0:01:00 minus one tick = 0:00:99. Reaching 0:00:00 sets done=1 and stops the counters.
- Clear edge, in STOP or DONE:
  - zeroes the time, prescaler, done and lap_lost;
  - flushes the FIFO.
  - Ignored in RUN.
- load, in STOP or DONE:
  - each field is saturated: ms10 to 99, sec to 59, min to MIN_MAX;
  - zeroes the prescaler and clears done.
  - Ignored in RUN.
- Lap edge in RUN: pushes the current {minute, second, ms10}. Ignored outside RUN.
- Full FIFO on a lap: the oldest entry is dropped, the new one is written, and lap_lost is set.
- Simultaneous events:
  - Lap and tick in the same cycle: the capture gets the pre-tick value.
  - Push and lap_rd in the same cycle: both happen and lap_cnt is unchanged.
  - lap_rd when empty: ignored.
  - Clear and load in the same cycle: clear wins.

## Timing
- Reset value: every output and internal register is 0. The state is STOP and the mode is up.
- Time outputs change on the mclk edge after the prescaler reaches DIV-1. Ticks are exactly DIV cycles apart.
- Button to effect: 3 cycles after a clear_btn/lap_btn rise, the counters or FIFO are updated.
- load: outputs updated on the next edge.
- done and running are registered and change on the same edge as the state change.
- lap_data/lap_valid: updated on the edge after a push or pop. There is no bypass from an empty FIFO.
- Reset asserted mid-count: the block returns to the reset state immediately, asynchronously. Counting resumes from 0 after release.

## Structure
- stopwatch_pkg:
  - state encoding STOP/RUN/DONE;
  - constants MS10_MAX=99 and SEC_MAX=59;
  - lap entry width 24.
- Sub-module lap_fifo:
  - parameter DEPTH;
  - circular buffer with an overwrite-oldest push;
  - outputs data/valid/cnt/lost.
- Edge detection, prescaler and BCD-free binary counters live in the top module.

## Test plan
Benches use CLK_HZ=1000, TICK_HZ=100, so DIV=10.
- Up count from reset, run=1 for 1000 cycles: result 0:01:00. Ticks are 10 cycles apart.
- load 2:59:99 at MIN_MAX=2, up mode, one tick: result 0:00:00 with a 1-cycle ovf.
- Down mode, load 0:01:00, run: next tick gives 0:00:99. After 100 ticks, done=1, the state is DONE and the value holds at 0:00:00.
- Run 25 cycles, pause 50, resume: the next tick arrives 5 cycles after resume.
- Five laps in RUN with LAP_DEPTH=4: lap_cnt=4 and lap_lost=1. The head is the second capture. Four lap_rd pops return captures 2–5.
- Clear edge during RUN: no change. Clear edge in STOP: time 0, FIFO empty, lap_lost=0, 3 cycles after the rise.
